// File: rtl/count_seq_checker.sv
// count_seq_checker
// Watches an 8-bit free-running enable counter and its enable, one sample per
// clock. Locks onto the sequence after LOCK_N consecutive good steps, then
// counts valid 255->0 wraps and freezes on the first bad step, keeping the
// expected and observed values of that step for debug.
module count_seq_checker #(
   parameter int LOCK_N = 4,   // consecutive good samples needed to lock (1..15)
   parameter int WRAP_W = 8    // width of the saturating wrap counter (1..16)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en_in,
   input  logic [7:0]        cnt_in,
   output logic              locked,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err,
   output logic [7:0]        err_exp,
   output logic [7:0]        err_got,
   output logic [1:0]        state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACQ   = 2'd1;
   localparam logic [1:0] TRACK = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   localparam logic [3:0]        LOCK_TARGET = 4'(LOCK_N);
   localparam logic [WRAP_W-1:0] WRAP_ONE    = WRAP_W'(1);

   logic [1:0]        state_reg,      state_next;
   logic [7:0]        prev_cnt_reg,   prev_cnt_next;
   logic              prev_en_reg,    prev_en_next;
   logic [3:0]        match_cnt_reg,  match_cnt_next;
   logic              locked_reg,     locked_next;
   logic              wrap_pulse_reg, wrap_pulse_next;
   logic [WRAP_W-1:0] wrap_cnt_reg,   wrap_cnt_next;
   logic              err_reg,        err_next;
   logic [7:0]        err_exp_reg,    err_exp_next;
   logic [7:0]        err_got_reg,    err_got_next;

   logic [7:0]        exp_val;
   logic              match;
   logic              is_wrap;
   logic [3:0]        match_inc;

   // Value the counter must show this edge given what it showed (and was told) last edge
   always_comb begin
      exp_val   = prev_en_reg ? (prev_cnt_reg + 8'd1) : prev_cnt_reg;
      match     = (cnt_in == exp_val);
      is_wrap   = prev_en_reg && (prev_cnt_reg == 8'hFF) && (cnt_in == 8'h00);
      match_inc = match_cnt_reg + 4'd1;
   end

   // Next-state: sequence tracking FSM, statistics and first-error capture
   always_comb begin
      state_next      = state_reg;
      prev_cnt_next   = prev_cnt_reg;
      prev_en_next    = prev_en_reg;
      match_cnt_next  = match_cnt_reg;
      locked_next     = locked_reg;
      wrap_pulse_next = 1'b0;
      wrap_cnt_next   = wrap_cnt_reg;
      err_next        = err_reg;
      err_exp_next    = err_exp_reg;
      err_got_next    = err_got_reg;

      // The sample history is frozen once a fault is latched so the
      // recorded context stays meaningful; IDLE recaptures it anyway.
      if (state_reg != FAULT) begin
         prev_cnt_next = cnt_in;
         prev_en_next  = en_in;
      end

      if (clr) begin
         // Clear beats any simultaneous mismatch or wrap on this edge.
         state_next     = IDLE;
         match_cnt_next = 4'd0;
         locked_next    = 1'b0;
         wrap_cnt_next  = '0;
         err_next       = 1'b0;
         err_exp_next   = 8'd0;
         err_got_next   = 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               // First sample only seeds the history; nothing to compare yet.
               state_next     = ACQ;
               match_cnt_next = 4'd0;
            end
            ACQ: begin
               if (match) begin
                  match_cnt_next = match_inc;
                  if (match_inc == LOCK_TARGET) begin
                     state_next  = TRACK;
                     locked_next = 1'b1;
                  end
               end else begin
                  match_cnt_next = 4'd0;
               end
            end
            TRACK: begin
               if (!match) begin
                  state_next   = FAULT;
                  locked_next  = 1'b0;
                  err_next     = 1'b1;
                  err_exp_next = exp_val;
                  err_got_next = cnt_in;
               end else if (is_wrap) begin
                  wrap_pulse_next = 1'b1;
                  if (wrap_cnt_reg != '1) begin
                     wrap_cnt_next = wrap_cnt_reg + WRAP_ONE;
                  end
               end
            end
            default: begin
               // FAULT: hold everything until clr or rst.
               state_next = FAULT;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         prev_cnt_reg   <= 8'd0;
         prev_en_reg    <= 1'b0;
         match_cnt_reg  <= 4'd0;
         locked_reg     <= 1'b0;
         wrap_pulse_reg <= 1'b0;
         wrap_cnt_reg   <= '0;
         err_reg        <= 1'b0;
         err_exp_reg    <= 8'd0;
         err_got_reg    <= 8'd0;
      end else begin
         state_reg      <= state_next;
         prev_cnt_reg   <= prev_cnt_next;
         prev_en_reg    <= prev_en_next;
         match_cnt_reg  <= match_cnt_next;
         locked_reg     <= locked_next;
         wrap_pulse_reg <= wrap_pulse_next;
         wrap_cnt_reg   <= wrap_cnt_next;
         err_reg        <= err_next;
         err_exp_reg    <= err_exp_next;
         err_got_reg    <= err_got_next;
      end
   end

   assign state      = state_reg;
   assign locked     = locked_reg;
   assign wrap_pulse = wrap_pulse_reg;
   assign wrap_cnt   = wrap_cnt_reg;
   assign err        = err_reg;
   assign err_exp    = err_exp_reg;
   assign err_got    = err_got_reg;

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker: a main instance (WRAP_W=8) and a
// saturation instance (WRAP_W=2) share the same stimulus. A behavioural
// reference pushes expected outputs to queues as each sample is driven; they
// are popped and compared after the edge, alongside directed checks.
module tb_count_seq_checker;

   localparam int LOCK_N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       en_in;
   logic [7:0] cnt_in;

   logic       locked,   wrap_pulse,   err;
   logic [7:0] wrap_cnt, err_exp,      err_got;
   logic [1:0] state;

   logic       locked_s, wrap_pulse_s, err_s;
   logic [1:0] wrap_cnt_s;
   logic [7:0] err_exp_s, err_got_s;
   logic [1:0] state_s;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [1:0] m_state;
   logic [7:0] m_prev_cnt;
   logic       m_prev_en;
   int         m_match;
   logic       m_locked, m_pulse, m_err;
   logic [7:0] m_w8, m_exp, m_got;
   logic [1:0] m_w2;

   logic [31:0] q_main[$];
   logic [31:0] q_sat[$];

   logic [7:0] c;
   int pulses, pulses_s, sat_idx;
   bit sat_mode;
   int sat_tab[6] = '{1, 2, 3, 3, 3, 3};

   always #5 clk = ~clk;

   count_seq_checker #(.LOCK_N(LOCK_N), .WRAP_W(8)) dut (
      .clk(clk), .rst(rst), .clr(clr), .en_in(en_in), .cnt_in(cnt_in),
      .locked(locked), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
      .err(err), .err_exp(err_exp), .err_got(err_got), .state(state)
   );

   count_seq_checker #(.LOCK_N(LOCK_N), .WRAP_W(2)) dut_sat (
      .clk(clk), .rst(rst), .clr(clr), .en_in(en_in), .cnt_in(cnt_in),
      .locked(locked_s), .wrap_pulse(wrap_pulse_s), .wrap_cnt(wrap_cnt_s),
      .err(err_s), .err_exp(err_exp_s), .err_got(err_got_s), .state(state_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      assert (got === want) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
   endtask

   task automatic model_reset();
      m_state = 2'd0; m_prev_cnt = 8'd0; m_prev_en = 1'b0; m_match = 0;
      m_locked = 1'b0; m_pulse = 1'b0; m_err = 1'b0;
      m_w8 = 8'd0; m_w2 = 2'd0; m_exp = 8'd0; m_got = 8'd0;
   endtask

   // what the checker should hold after the coming edge
   task automatic model_edge(input logic k_clr, input logic k_en, input logic [7:0] k_cnt);
      logic [7:0] e;
      logic       hit;
      logic [1:0] old;
      old     = m_state;
      e       = m_prev_en ? 8'(m_prev_cnt + 8'd1) : m_prev_cnt;
      hit     = (k_cnt == e);
      m_pulse = 1'b0;
      if (k_clr) begin
         m_state = 2'd0; m_match = 0; m_locked = 1'b0;
         m_w8 = 8'd0; m_w2 = 2'd0; m_err = 1'b0; m_exp = 8'd0; m_got = 8'd0;
      end else if (m_state == 2'd0) begin
         m_state = 2'd1; m_match = 0;
      end else if (m_state == 2'd1) begin
         if (hit) begin
            m_match++;
            if (m_match == LOCK_N) begin
               m_state = 2'd2; m_locked = 1'b1;
            end
         end else begin
            m_match = 0;
         end
      end else if (m_state == 2'd2) begin
         if (!hit) begin
            m_state = 2'd3; m_locked = 1'b0; m_err = 1'b1; m_exp = e; m_got = k_cnt;
         end else if (m_prev_en && m_prev_cnt == 8'd255 && k_cnt == 8'd0) begin
            m_pulse = 1'b1;
            if (m_w8 != 8'hFF) m_w8 = m_w8 + 8'd1;
            if (m_w2 != 2'b11) m_w2 = m_w2 + 2'd1;
         end
      end
      if (old != 2'd3) begin
         m_prev_cnt = k_cnt; m_prev_en = k_en;
      end
   endtask

   // drive one sample, predict, then compare after the edge
   task automatic step(input logic k_clr, input logic k_en, input logic [7:0] k_cnt);
      logic [31:0] want_main, want_sat;
      clr = k_clr; en_in = k_en; cnt_in = k_cnt;
      model_edge(k_clr, k_en, k_cnt);
      q_main.push_back(32'({m_state, m_locked, m_pulse, m_w8, m_err, m_exp, m_got}));
      q_sat.push_back(32'({m_state, m_locked, m_pulse, m_w2, m_err, m_exp, m_got}));
      @(posedge clk);
      #1;
      want_main = q_main.pop_front();
      want_sat  = q_sat.pop_front();
      chk("cycle_main", 32'({state, locked, wrap_pulse, wrap_cnt, err, err_exp, err_got}), want_main);
      chk("cycle_sat", 32'({state_s, locked_s, wrap_pulse_s, wrap_cnt_s, err_s, err_exp_s, err_got_s}), want_sat);
      if (wrap_pulse) pulses++;
      if (wrap_pulse_s) begin
         pulses_s++;
         if (sat_mode && sat_idx < 6) begin
            chk("sat_seq", 32'(wrap_cnt_s), 32'(sat_tab[sat_idx]));
            sat_idx++;
         end
      end
   endtask

   // free-running counter stimulus
   task automatic run(input int n, input logic k_en);
      for (int i = 0; i < n; i++) begin
         step(1'b0, k_en, c);
         if (k_en) c = c + 8'd1;
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en_in = 1'b0; cnt_in = 8'd0; c = 8'd0;
      pulses = 0; pulses_s = 0; sat_idx = 0; sat_mode = 1'b0;
      model_reset();

      // bring-up
      repeat (3) @(posedge clk);
      #1;
      chk("reset_main", 32'({state, locked, wrap_pulse, wrap_cnt, err, err_exp, err_got}), 32'd0);
      chk("reset_sat", 32'({state_s, locked_s, wrap_pulse_s, wrap_cnt_s, err_s, err_exp_s, err_got_s}), 32'd0);
      rst = 1'b0;
      run(1, 1'b1);
      chk("bringup_state_acq", 32'(state), 32'd1);
      run(3, 1'b1);
      chk("bringup_unlocked", 32'(locked), 32'd0);
      run(1, 1'b1);
      chk("bringup_locked", 32'(locked), 32'd1);
      chk("bringup_state_track", 32'(state), 32'd2);
      chk("bringup_err", 32'(err), 32'd0);

      // long run through one wrap, then hold
      run(265, 1'b1);
      chk("long_pulses", 32'(pulses), 32'd1);
      chk("long_wrap_cnt", 32'(wrap_cnt), 32'd1);
      run(10, 1'b0);
      chk("hold_locked", 32'(locked), 32'd1);
      chk("hold_err", 32'(err), 32'd0);
      chk("hold_pulses", 32'(pulses), 32'd1);

      // fault injection: 10 -> 12
      while (c != 8'd10) run(1, 1'b1);
      step(1'b0, 1'b1, 8'd10);
      step(1'b0, 1'b1, 8'd12);
      chk("fault_err", 32'(err), 32'd1);
      chk("fault_exp", 32'(err_exp), 32'd11);
      chk("fault_got", 32'(err_got), 32'd12);
      chk("fault_state", 32'(state), 32'd3);
      chk("fault_locked", 32'(locked), 32'd0);
      step(1'b0, 1'b1, 8'd20);
      chk("fault2_exp", 32'(err_exp), 32'd11);
      chk("fault2_got", 32'(err_got), 32'd12);
      chk("fault2_wrap_cnt", 32'(wrap_cnt), 32'd2);

      // clear out of FAULT, relock, then clear against a mismatch
      c = 8'd50;
      step(1'b1, 1'b1, c);
      c = c + 8'd1;
      run(5, 1'b1);
      chk("relock_locked", 32'(locked), 32'd1);
      step(1'b1, 1'b1, 8'(c + 8'd7));
      c = c + 8'd1;
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_wrap_cnt", 32'(wrap_cnt), 32'd0);
      chk("clr_state", 32'(state), 32'd0);
      run(4, 1'b1);
      chk("clr_unlocked", 32'(locked), 32'd0);
      run(1, 1'b1);
      chk("clr_relocked", 32'(locked), 32'd1);

      // saturation: six wraps on the 2-bit counter
      c = 8'd200;
      step(1'b1, 1'b1, c);
      c = c + 8'd1;
      run(5, 1'b1);
      sat_mode = 1'b1; pulses_s = 0; pulses = 0;
      run(6 * 256, 1'b1);
      sat_mode = 1'b0;
      chk("sat_pulses", 32'(pulses_s), 32'd6);
      chk("sat_idx", 32'(sat_idx), 32'd6);
      chk("sat_final", 32'(wrap_cnt_s), 32'd3);
      chk("unsat_final", 32'(wrap_cnt), 32'd6);
      chk("unsat_pulses", 32'(pulses), 32'd6);

      // async reset pulse between edges while tracking
      chk("pre_rst_locked", 32'(locked), 32'd1);
      rst = 1'b1;
      #2;
      chk("async_rst_main", 32'({state, locked, wrap_pulse, wrap_cnt, err, err_exp, err_got}), 32'd0);
      chk("async_rst_sat", 32'({state_s, locked_s, wrap_pulse_s, wrap_cnt_s, err_s, err_exp_s, err_got_s}), 32'd0);
      rst = 1'b0;
      model_reset();
      run(4, 1'b1);
      chk("rst_unlocked", 32'(locked), 32'd0);
      run(1, 1'b1);
      chk("rst_relocked", 32'(locked), 32'd1);
      chk("rst_err", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
